// File: rtl/philv_alu_pkg.sv
// Shared constants for the Philosophy-V execute-stage ALU slice:
// ALU function codes, funct3 encodings and the funct7 "alternate op" bit.
package philv_alu_pkg;

  localparam int ALU_FUNCT_WIDTH = 4;

  // ALU function codes (values 10..15 are unused and yield a zero result)
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SLL  = 4'd2;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SLT  = 4'd3;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SLTU = 4'd4;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_OR   = 4'd8;
  localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_AND  = 4'd9;

  // RV32I funct3 encodings for OP / OP-IMM
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // funct7 bit that selects SUB over ADD and SRA over SRL
  localparam int FUNCT7_ALT_BIT = 5;

endpackage

// File: rtl/alu.sv
// RV32I-style integer ALU, purely combinational.
// Arithmetic wraps modulo 2^N; shifts use only the low log2(N) bits of y.
module alu
  import philv_alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [ALU_FUNCT_WIDTH-1:0] funct,
  input  logic [N-1:0]               x,
  input  logic [N-1:0]               y,
  output logic [N-1:0]               z
);

  localparam int SHW = $clog2(N);

  logic [SHW-1:0] shamt;
  logic           slt_flag;
  logic           sltu_flag;

  assign shamt     = y[SHW-1:0];
  assign slt_flag  = $signed(x) < $signed(y);
  assign sltu_flag = x < y;

  // Select the result for the current function code; unused codes give zero
  always_comb begin
    z = '0;
    case (funct)
      ALU_ADD:  z = x + y;
      ALU_SUB:  z = x - y;
      ALU_SLL:  z = x << shamt;
      ALU_SLT:  z = {{(N-1){1'b0}}, slt_flag};
      ALU_SLTU: z = {{(N-1){1'b0}}, sltu_flag};
      ALU_XOR:  z = x ^ y;
      ALU_SRL:  z = x >> shamt;
      ALU_SRA:  z = $unsigned($signed(x) >>> shamt);
      ALU_OR:   z = x | y;
      ALU_AND:  z = x & y;
      default:  z = '0;
    endcase
  end

endmodule

// File: rtl/alu_decoder.sv
// Combinational funct3/funct7 -> ALU function code decoder.
// Only funct7[5] participates; the remaining funct7 bits are don't-care.
module alu_decoder
  import philv_alu_pkg::*;
(
  input  logic [2:0]                 funct3,
  input  logic [6:0]                 funct7,
  output logic [ALU_FUNCT_WIDTH-1:0] alu_funct
);

  logic alt_op;
  assign alt_op = funct7[FUNCT7_ALT_BIT];

  // Ignored funct7 bits, collected so they are visibly intentional.
  logic unused_funct7_bits;
  assign unused_funct7_bits = ^{funct7[6], funct7[4:0]};

  // Map funct3 (plus the alternate-op bit) onto the ALU code table
  always_comb begin
    alu_funct = ALU_ADD;
    case (funct3)
      F3_ADD_SUB: alu_funct = alt_op ? ALU_SUB : ALU_ADD;
      F3_SLL:     alu_funct = ALU_SLL;
      F3_SLT:     alu_funct = ALU_SLT;
      F3_SLTU:    alu_funct = ALU_SLTU;
      F3_XOR:     alu_funct = ALU_XOR;
      F3_SRL_SRA: alu_funct = alt_op ? ALU_SRA : ALU_SRL;
      F3_OR:      alu_funct = ALU_OR;
      F3_AND:     alu_funct = ALU_AND;
      default:    alu_funct = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/doubleRegister.sv
// Enabled operand register pair with synchronous active-high clear.
// Clear wins over load; with enable low both operands hold.
module doubleRegister #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [BUS_WIDTH-1:0] dA,
  input  logic [BUS_WIDTH-1:0] dB,
  output logic [BUS_WIDTH-1:0] qA,
  output logic [BUS_WIDTH-1:0] qB
);

  logic [BUS_WIDTH-1:0] qa_q, qa_d;
  logic [BUS_WIDTH-1:0] qb_q, qb_d;

  // Next operand values: load on enable, otherwise hold
  always_comb begin
    qa_d = qa_q;
    qb_d = qb_q;
    if (ena) begin
      qa_d = dA;
      qb_d = dB;
    end
  end

  // Operand state; clear takes priority over any load
  always_ff @(posedge clk) begin
    if (rst) begin
      qa_q <= '0;
      qb_q <= '0;
    end else begin
      qa_q <= qa_d;
      qb_q <= qb_d;
    end
  end

  assign qA = qa_q;
  assign qB = qb_q;

endmodule

// File: rtl/philv_alu_stage.sv
// Philosophy-V execute-stage slice: registered operands feeding an ALU whose
// function is decoded combinationally from funct3/funct7. The function path
// has no register, so funct fields must be aligned with the registered operands.
module philv_alu_stage
  import philv_alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic [2:0]                 funct3,
  input  logic [6:0]                 funct7,
  input  logic [N-1:0]               dA,
  input  logic [N-1:0]               dB,
  output logic [N-1:0]               qA,
  output logic [N-1:0]               qB,
  output logic [ALU_FUNCT_WIDTH-1:0] alu_funct,
  output logic [N-1:0]               c,
  output logic                       zero
);

  doubleRegister #(
    .BUS_WIDTH(N)
  ) u_operands (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .dA  (dA),
    .dB  (dB),
    .qA  (qA),
    .qB  (qB)
  );

  alu_decoder u_decoder (
    .funct3    (funct3),
    .funct7    (funct7),
    .alu_funct (alu_funct)
  );

  alu #(
    .N(N)
  ) u_alu (
    .funct (alu_funct),
    .x     (qA),
    .y     (qB),
    .z     (c)
  );

  assign zero = ~|c;

endmodule

// File: tb/tb_philv_alu_stage.sv
// Scoreboard bench for philv_alu_stage: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_philv_alu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] dA, dB;
  logic [31:0] qA, qB;
  logic [3:0]  alu_funct;
  logic [31:0] c;
  logic        zero;

  always #5 clk = ~clk;

  philv_alu_stage #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .funct3    (funct3),
    .funct7    (funct7),
    .dA        (dA),
    .dB        (dB),
    .qA        (qA),
    .qB        (qB),
    .alu_funct (alu_funct),
    .c         (c),
    .zero      (zero)
  );

  typedef struct {
    string       name;
    bit          chk_c;
    logic [31:0] c;
    logic        zero;
    bit          chk_f;
    logic [3:0]  f;
    bit          chk_q;
    logic [31:0] qa;
    logic [31:0] qb;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Monitor: compare every pending expectation against the settled outputs
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      $display("check %s: c=%h zero=%b f=%0d qA=%h qB=%h", e.name, c, zero, alu_funct, qA, qB);
      if (e.chk_c) begin
        n_total++;
        if (c === e.c) n_pass++;
        else $display("FAIL %s.c: got %h expected %h", e.name, c, e.c);
        n_total++;
        if (zero === e.zero) n_pass++;
        else $display("FAIL %s.zero: got %b expected %b", e.name, zero, e.zero);
      end
      if (e.chk_f) begin
        n_total++;
        if (alu_funct === e.f) n_pass++;
        else $display("FAIL %s.alu_funct: got %0d expected %0d", e.name, alu_funct, e.f);
      end
      if (e.chk_q) begin
        n_total++;
        if (qA === e.qa) n_pass++;
        else $display("FAIL %s.qA: got %h expected %h", e.name, qA, e.qa);
        n_total++;
        if (qB === e.qb) n_pass++;
        else $display("FAIL %s.qB: got %h expected %h", e.name, qB, e.qb);
      end
    end
  end

  // Load operands with one enabled edge, leave enable low afterwards
  task automatic load(input logic [31:0] a, input logic [31:0] b);
    dA  = a;
    dB  = b;
    ena = 1'b1;
    @(posedge clk);
    #1;
    ena = 1'b0;
  endtask

  // Apply a function, queue the expected result, wait for the monitor
  task automatic chk(input string name, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] ec, input bit chk_q,
                     input logic [31:0] eqa, input logic [31:0] eqb);
    exp_t e;
    funct3 = f3;
    funct7 = f7;
    e.name  = name;
    e.chk_c = 1'b1;
    e.c     = ec;
    e.zero  = (ec == 32'd0);
    e.chk_f = 1'b0;
    e.f     = 4'd0;
    e.chk_q = chk_q;
    e.qa    = eqa;
    e.qb    = eqb;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic chk_dec(input string name, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [3:0] ef);
    exp_t e;
    funct3 = f3;
    funct7 = f7;
    e.name  = name;
    e.chk_c = 1'b0;
    e.c     = '0;
    e.zero  = 1'b0;
    e.chk_f = 1'b1;
    e.f     = ef;
    e.chk_q = 1'b0;
    e.qa    = '0;
    e.qb    = '0;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  // Hand-written code table, indexed by {funct7[5], funct3}
  logic [3:0] dec_tbl [16] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9,
                               4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9};
  logic [6:0] f7_set [3] = '{7'h00, 7'h20, 7'h7F};

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  // Directed stimulus
  initial begin
    rst    = 1'b1;
    ena    = 1'b1;
    dA     = 32'hFFFF_FFFF;
    dB     = 32'd5;
    funct3 = 3'b000;
    funct7 = 7'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ena = 1'b0;

    // Reset state: every valid code gives zero
    chk("reset_add", 3'b000, 7'h00, 32'd0, 1'b1, 32'd0, 32'd0);
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("reset_f3_%0d", i), i[2:0], 7'h00, 32'd0, 1'b0, 32'd0, 32'd0);
    end
    chk("reset_sra", 3'b101, 7'h20, 32'd0, 1'b0, 32'd0, 32'd0);

    // Load / enable hold
    load(32'd7, 32'd3);
    dA = 32'd100;
    dB = 32'd200;
    chk("en_add", 3'b000, 7'h00, 32'd10, 1'b1, 32'd7, 32'd3);
    chk("en_sub", 3'b000, 7'h20, 32'd4,  1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("hold_add", 3'b000, 7'h00, 32'd10, 1'b1, 32'd7, 32'd3);

    // Mid-run reset with enable low clears operands
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst", 3'b000, 7'h00, 32'd0, 1'b1, 32'd0, 32'd0);

    // Signed vs unsigned compare
    load(32'hFFFF_FFFF, 32'd1);
    chk("slt",  3'b010, 7'h00, 32'd1, 1'b1, 32'hFFFF_FFFF, 32'd1);
    chk("sltu", 3'b011, 7'h00, 32'd0, 1'b0, 32'd0, 32'd0);
    chk("add_wrap", 3'b000, 7'h00, 32'd0, 1'b0, 32'd0, 32'd0);
    load(32'd1, 32'd1);
    chk("sub_zero", 3'b000, 7'h20, 32'd0, 1'b0, 32'd0, 32'd0);
    load(32'd1, 32'd2);
    chk("sub_neg", 3'b000, 7'h20, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0);

    // Shifts: only the low 5 bits of y count
    load(32'h8000_0000, 32'h0000_0024);
    chk("srl", 3'b101, 7'h00, 32'h0800_0000, 1'b0, 32'd0, 32'd0);
    chk("sra", 3'b101, 7'h20, 32'hF800_0000, 1'b0, 32'd0, 32'd0);
    chk("sll_amt4", 3'b001, 7'h00, 32'h0000_0000, 1'b0, 32'd0, 32'd0);
    load(32'd1, 32'd31);
    chk("sll31", 3'b001, 7'h00, 32'h8000_0000, 1'b0, 32'd0, 32'd0);

    // Bitwise logic
    load(32'hF0F0_F0F0, 32'hFF00_FF00);
    chk("and", 3'b111, 7'h00, 32'hF000_F000, 1'b0, 32'd0, 32'd0);
    chk("or",  3'b110, 7'h00, 32'hFFF0_FFF0, 1'b0, 32'd0, 32'd0);
    chk("xor", 3'b100, 7'h00, 32'h0FF0_0FF0, 1'b0, 32'd0, 32'd0);

    // Decoder sweep; 0x7F must decode like 0x20
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 8; i++) begin
        logic [3:0] idx;
        idx = {(f7_set[j] != 7'h00), i[2:0]};
        chk_dec($sformatf("dec_f3_%0d_f7_%h", i, f7_set[j]), i[2:0], f7_set[j], dec_tbl[idx]);
      end
    end

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/philv_alu_stage.md
# philv_alu_stage

Execute-stage datapath slice of the Philosophy-V core. Two register-file read values are captured in an enabled operand register pair. The instruction's funct3/funct7 fields are decoded combinationally into an ALU function code, and an RV32I-style integer ALU combines the registered operands into the result `c`. It sits between the register file / instruction register and the write-back path.

## Interface
- `N`, default 32: data width of operands and result; must be ≥ 8.
- `clk` input, 1: sole clock; all state updates on the rising edge.
- `rst` input, 1: reset is synchronous and active-high.
- `ena` input, 1: operand-register load enable.
- `funct3` input, 3: instruction bits [14:12].
- `funct7` input, 7: instruction bits [31:25].
- `dA` input, N: register-file read port 0 (rs1 value).
- `dB` input, N: register-file read port 1 (rs2 value).
- `qA` output, N: registered operand A (ALU x).
- `qB` output, N: registered operand B (ALU y).
- `alu_funct` output, 4: decoded ALU function code.
- `c` output, N: ALU result.
- `zero` output, 1: high when `c == 0`.

## Operation
- Operand register, rising edge:
  - `rst`=1 → `qA`, `qB` ← 0.
  - Else `ena`=1 → `qA` ← `dA`, `qB` ← `dB`.
  - Else hold.
  - `rst` has priority over `ena`.
- Decoder (combinational) uses `funct3` and `funct7[5]` only; the other `funct7` bits are ignored. `alu_funct` codes:
  - `funct3` 000: ADD=0 if `funct7[5]`=0, SUB=1 if `funct7[5]`=1.
  - `funct3` 001: SLL=2.
  - `funct3` 010: SLT=3.
  - `funct3` 011: SLTU=4.
  - `funct3` 100: XOR=5.
  - `funct3` 101: SRL=6 if `funct7[5]`=0, SRA=7 if `funct7[5]`=1.
  - `funct3` 110: OR=8.
  - `funct3` 111: AND=9.
- ALU (combinational), with x=`qA` and y=`qB`:
  - ADD/SUB: modulo 2^N; carry and overflow are discarded.
  - SLL/SRL/SRA: shift amount is y[$clog2(N)-1:0], upper bits ignored. SRA replicates x[N-1].
  - SLT: signed compare; SLTU: unsigned compare. Result is {N-1 zeros, flag}.
  - XOR/OR/AND: bitwise.
  - Codes 10–15 are unused: `c` = 0.
- `zero` = ~|`c`.

## Timing
- Operand latency: `dA`/`dB` appear on `qA`/`qB` and affect `c` one cycle after the edge where `ena`=1.
- Function path has zero latency: changes on `funct3`/`funct7` change `alu_funct` and `c` in the same cycle, with no register. The upstream sequencer must present funct fields aligned with the registered operands.
- After reset, `qA`=`qB`=0, so `c`=0 and `zero`=1 for every valid function code.
- If `rst` is asserted mid-operation, the operands clear at the next edge; there is no other state.
- `ena`=0 for multiple cycles: operands are frozen, and `c` still follows `funct` changes.

## Structure
- Shared package `philv_alu_pkg` holds:
  - `ALU_FUNCT_WIDTH`=4.
  - The ten `alu_funct` localparams (ADD…AND).
  - Funct3 constants and the `FUNCT7_ALT_BIT`=5 index.
- Three sub-modules, instantiated by the top:
  - `alu_decoder`: funct3/funct7 → alu_funct.
  - `alu`: parameter N, ports funct, x, y, z.
  - `doubleRegister`: parameter BUS_WIDTH, ports clk, rst, ena, dA, dB, qA, qB.

## Test plan
- Reset: drive `dA`=0xFFFFFFFF, `dB`=5, `ena`=1, `rst`=1 for 1 edge → `qA`=`qB`=0, `c`=0, `zero`=1.
- Load/enable: load `dA`=7, `dB`=3 with `ena`=1, then drive `ena`=0 with new `dA`=100.
  - ADD → `c`=10; SUB (`funct7`=0x20) → `c`=4.
  - `qA` stays 7 while `ena`=0.
- Signed vs unsigned, with x=0xFFFFFFFF, y=1:
  - SLT → `c`=1; SLTU → `c`=0.
  - SUB with x=y=1 → `c`=0, `zero`=1.
- Shifts, with x=0x80000000, y=0x00000024 (amount 4):
  - SRL → 0x08000000; SRA → 0xF8000000; SLL of 1 by 31 → 0x80000000.
- Logic, with x=0xF0F0F0F0, y=0xFF00FF00:
  - AND → 0xF000F000; OR → 0xFFF0FFF0; XOR → 0x0FF00FF0.
- Decoder sweep: all 8 funct3 × `funct7` ∈ {0x00, 0x20, 0x7F}.
  - `alu_funct` matches the code table.
  - 0x7F behaves as 0x20.
